// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - digit-serial add/subtract unit, LSB digit first
//
// Purpose: adds or subtracts two WIDTH-bit operands DIGIT bits per clock.
//          Operands are captured on start, then the result digits stream out
//          on s_out one per cycle while s_valid is high. A one-cycle done
//          pulse marks the registered full result on sum/cout/ovf.
// Parameters:
//   WIDTH   operand/result width in bits (must be a multiple of DIGIT)
//   DIGIT   bits processed per cycle
// Ports:
//   clk      in   single clock, rising edge
//   reset    in   asynchronous active-low reset
//   start    in   begin an operation (honoured only when idle)
//   sub      in   0 = a+b, 1 = a-b; sampled with start
//   a, b     in   operands, sampled with start
//   busy     out  high while an operation is in progress (RUN or DONE)
//   s_out    out  current result digit (zero outside RUN)
//   s_valid  out  s_out is valid
//   done     out  one-cycle completion pulse
//   sum      out  full result, stable from done until the next accepted start
//   cout     out  final carry-out; for subtract 1 means no borrow
//   ovf      out  two's-complement signed overflow

module digit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [DIGIT-1:0] s_out,
    output logic             s_valid,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    // Keep the counter at least one bit wide so NDIG == 1 still elaborates.
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    count;

    logic [DIGIT:0]         dsum;
    logic                   msb_cin;
    logic                   last_digit;
    logic [WIDTH+DIGIT-1:0] sum_shift;

    // Digit adder: low DIGIT bits are the result digit, top bit the carry-out.
    always_comb begin
        dsum = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]}
             + {{DIGIT{1'b0}}, carry};
    end

    // Carry into the digit's top bit, recovered from the sum bit itself:
    // s = a ^ b ^ cin, so cin = a ^ b ^ s. On the last digit this is the
    // carry into the word MSB, which gives overflow without a second adder.
    assign msb_cin    = op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ dsum[DIGIT-1];
    assign last_digit = (count == CW'(NDIG - 1));

    // New digit enters at the MSB end, everything else moves down one digit.
    assign sum_shift  = {dsum[DIGIT-1:0], sum};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_digit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && start) begin
            // Subtract as a + ~b + 1: invert b here and seed the carry with 1.
            op_a  <= a;
            op_b  <= b ^ {WIDTH{sub}};
            carry <= sub;
            count <= '0;
        end else if (state == RUN) begin
            carry <= dsum[DIGIT];
            op_a  <= op_a >> DIGIT;
            op_b  <= op_b >> DIGIT;
            sum   <= sum_shift[WIDTH+DIGIT-1:DIGIT];
            count <= count + 1'b1;
            if (last_digit) begin
                cout <= dsum[DIGIT];
                ovf  <= msb_cin ^ dsum[DIGIT];
            end
        end
    end

    assign busy    = (state != IDLE);
    assign s_valid = (state == RUN);
    assign done    = (state == DONE);
    assign s_out   = (state == RUN) ? dsum[DIGIT-1:0] : '0;

endmodule
